// File: rtl/ror_seq_pkg.sv
// Shared definitions for the sequential rotate controller: FSM state
// encoding, default datapath width and the matching rotate-count width.
package ror_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : ror_seq_pkg

// File: rtl/ror_seq_ctrl_ror_step.sv
// One-bit rotate stage. dir=0 rotates right (bit 0 leaves and wraps to the
// MSB); dir=1 rotates left (MSB leaves and wraps to bit 0). out_bit is the
// bit that wrapped around.
module ror_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    output logic [WIDTH-1:0] rotated,
    output logic             out_bit
);

    // Select right or left single-bit rotation.
    always_comb begin
        rotated = value;
        out_bit = 1'b0;
        if (dir) begin
            rotated = {value[WIDTH-2:0], value[WIDTH-1]};
            out_bit = value[WIDTH-1];
        end else begin
            rotated = {value[0], value[WIDTH-1:1]};
            out_bit = value[0];
        end
    end

endmodule : ror_step

// File: rtl/ror_seq_ctrl.sv
// Sequential rotate controller: latches an operand and amount on start,
// rotates one bit per clock, pulses done for one cycle on completion.
// Optional feature macro: ROR_SEQ_DIR_EN adds a 'dir' input (latched on
// start) selecting left rotation; without it the block rotates right only.
module ror_seq_ctrl
    import ror_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef ROR_SEQ_DIR_EN
    input  logic             dir,
`endif
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    // Count width follows the actual WIDTH parameter, not just the default.
    localparam int LCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LCNT_W-1:0] CNT_ZERO = LCNT_W'(0);
    localparam logic [LCNT_W-1:0] CNT_ONE  = LCNT_W'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [LCNT_W-1:0] r_count;
    logic [WIDTH-1:0]  r_result;
    logic              r_carry;
    logic [LCNT_W-1:0] w_amount;
    logic [WIDTH-1:0]  w_rotated;
    logic              w_out_bit;
    logic              w_dir;
    logic              w_unused_b;

    // Only the low bits of B form the rotate amount.
    assign w_amount   = B[LCNT_W-1:0];
    assign w_unused_b = ^B[WIDTH-1:LCNT_W];

`ifdef ROR_SEQ_DIR_EN
    logic r_dir;

    // Capture the rotate direction with each accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_dir <= dir;
        end else begin
            r_dir <= r_dir;
        end
    end

    assign w_dir = r_dir;
`else
    assign w_dir = 1'b0;
`endif

    ror_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value   (r_result),
        .dir     (w_dir),
        .rotated (w_rotated),
        .out_bit (w_out_bit)
    );

    // FSM state register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: start only in IDLE, abort only in RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (w_amount != CNT_ZERO) ? RUN : DONE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (r_count == CNT_ONE) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            RUN: begin
                busy = 1'b1;
                done = 1'b0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: latch on start, one rotate per RUN edge, freeze on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= CNT_ZERO;
            r_result <= {WIDTH{1'b0}};
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count  <= w_amount;
                        r_result <= A;
                        r_carry  <= 1'b0;
                    end else begin
                        r_count  <= r_count;
                        r_result <= r_result;
                        r_carry  <= r_carry;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_count  <= r_count;
                        r_result <= r_result;
                        r_carry  <= r_carry;
                    end else begin
                        r_count  <= r_count - CNT_ONE;
                        r_result <= w_rotated;
                        r_carry  <= w_out_bit;
                    end
                end
                default: begin
                    r_count  <= r_count;
                    r_result <= r_result;
                    r_carry  <= r_carry;
                end
            endcase
        end
    end

    assign result = r_result;
    assign carry  = r_carry;

endmodule : ror_seq_ctrl

// File: tb/tb_ror_seq_ctrl.sv
// Directed self-checking bench for ror_seq_ctrl (WIDTH=16).
// Cycle k is the interval after the k-th rising edge following the start edge.
module tb_ror_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
`ifdef ROR_SEQ_DIR_EN
    logic        dir;
`endif

    int errors;
    int checks;

    ror_seq_ctrl #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
`ifdef ROR_SEQ_DIR_EN
        .dir    (dir),
`endif
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h carry=%b, want 0 0 0000 0",
                     busy, done, result, carry);
        end
        reset = 1'b0;
        step();
    endtask

    // Start an operation of amount n and check busy/done every cycle.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input int n, input logic [15:0] exp_res, input logic exp_c,
                          input logic abort_at_start, input logic dir_v);
`ifdef ROR_SEQ_DIR_EN
        dir = dir_v;
`endif
        A = a; B = b; start = 1'b1; abort = abort_at_start;
        step();
        start = 1'b0; abort = 1'b0; A = ~a; B = 16'h0005;
`ifdef ROR_SEQ_DIR_EN
        dir = ~dir_v;
`endif
        for (int k = 1; k <= n + 1; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== (k == n + 1)) begin
                errors++;
                $display("FAIL %s_cycle%0d: busy=%b done=%b, want busy=1 done=%b",
                         name, k, busy, done, (k == n + 1));
            end
            if (k == n + 1) begin
                checks++;
                if (result !== exp_res || carry !== exp_c) begin
                    errors++;
                    $display("FAIL %s_value: result=%h carry=%b, want %h %b",
                             name, result, carry, exp_res, exp_c);
                end
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== exp_res || carry !== exp_c) begin
            errors++;
            $display("FAIL %s_after: busy=%b done=%b result=%h carry=%b, want 0 0 %h %b",
                     name, busy, done, result, carry, exp_res, exp_c);
        end
        if (dir_v) begin
            A = 16'h0000;
        end else begin
            A = 16'h0000;
        end
    endtask

    task automatic test_rotate();
        run_op("rot1",    16'h0001, 16'h0001, 1, 16'h8000, 1'b1, 1'b0, 1'b0);
        run_op("rot4",    16'h1234, 16'h0004, 4, 16'h4123, 1'b0, 1'b0, 1'b0);
        run_op("rot0",    16'hBEEF, 16'h0000, 0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        run_op("rot_msk", 16'h0007, 16'h0013, 3, 16'hE000, 1'b1, 1'b0, 1'b0);
        run_op("rot15",   16'h0003, 16'h000F, 15, 16'h0006, 1'b0, 1'b0, 1'b0);
        run_op("strt_ab", 16'h1234, 16'h0004, 4, 16'h4123, 1'b0, 1'b1, 1'b0);
    endtask

    // Abort mid-RUN; a start re-asserted during RUN must be ignored.
    task automatic test_abort(input string name, input logic [15:0] a,
                              input logic [15:0] exp_res, input logic exp_c);
        A = a; B = 16'h000F; start = 1'b1;
        step();
        start = 1'b0;
        step();
        A = 16'h0000; B = 16'h0001; start = 1'b1;
        step();
        start = 1'b0; abort = 1'b1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_pre: busy=%b done=%b, want 1 0", name, busy, done);
        end
        step();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== exp_res || carry !== exp_c) begin
                errors++;
                $display("FAIL %s_post%0d: busy=%b done=%b result=%h carry=%b, want 0 0 %h %b",
                         name, k, busy, done, result, carry, exp_res, exp_c);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_run();
        A = 16'h1234; B = 16'h0008; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h carry=%b, want 0 0 0000 0",
                     busy, done, result, carry);
        end
        step();
        checks++;
        if (busy !== 1'b0 || result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_prio: busy=%b result=%h, want 0 0000", busy, result);
        end
        run_op("post_rst", 16'h8001, 16'h0002, 2, 16'h6000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        start  = 1'b0;
        abort  = 1'b0;
        A      = 16'h0000;
        B      = 16'h0000;
`ifdef ROR_SEQ_DIR_EN
        dir    = 1'b0;
`endif
        test_reset();
        test_rotate();
        test_abort("abort_ff", 16'hFFFF, 16'hFFFF, 1'b1);
        test_abort("abort_01", 16'h0001, 16'h4000, 1'b0);
        test_reset_mid_run();
`ifdef ROR_SEQ_DIR_EN
        run_op("left1", 16'h8000, 16'h0001, 1, 16'h0001, 1'b1, 1'b0, 1'b1);
        run_op("left4", 16'h1234, 16'h0004, 4, 16'h2341, 1'b1, 1'b0, 1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ror_seq_ctrl
